i2c_regfile_ctl: RTL and testbench
==================================

Name: i2c_regfile_ctl

Overview:
Parametrised register-file back end for the byte-level interface of i2c_slave; the generalised successor of the fixed 1-byte-index test RAM.
- Index width is 1 or 2 bytes; depth, wrap policy and a read-only upper region are configurable.
- Adds a local host port for fabric-side access and a write-completion event.
- Sits between an i2c_slave instance (address match handled there) and user logic.

Parameters:
DEPTH, 16, number of 8-bit registers, 1..2**(8*IDX_BYTES)
IDX_BYTES, 1, register-index bytes sent after a write address, 1 or 2
WRAP, 1, 1: pointer wraps DEPTH-1 -> 0; 0: pointer saturates at DEPTH
RO_BASE, DEPTH, indices >= RO_BASE are read-only from I2C (host may still write)
FILL, 8'hFF, read data for indices >= DEPTH

Ports:
clk  in  1  system clock
aresetn  in  1  reset, asynchronous, active-low
slv_start  in  1  pulse: START/repeated START addressed to this slave
slv_rd  in  1  direction bit, qualified by slv_start (1 = read)
slv_stop  in  1  pulse: STOP seen
slv_ws  in  1  pulse: received byte valid on slv_wdat
slv_wdat  in  8  received byte
slv_rs  in  1  pulse: slave consumed slv_rdat, advance
slv_rdat  out  8  byte the slave transmits next
host_addr  in  IW=8*IDX_BYTES  host register index
host_we  in  1  host write strobe
host_wdat  in  8  host write data
host_rdat  out  8  mem[host_addr] (FILL if out of range), 1-cycle latency
host_coll  out  1  pulse: host write lost to same-cycle I2C write, same index
wr_done  out  1  pulse: STOP/restart closed a write phase with >=1 data byte
wr_first  out  IW  index of first data byte in that phase
wr_count  out  IW+1  data bytes accepted in that phase, including RO/out-of-range discards

Behaviour:
- Reset (aresetn=0, async): state=IDLE; base=ptr=0; all mem=0; slv_rdat=mem[0]=0; host_rdat=0; host_coll=wr_done=0; wr_first=wr_count=0.
- Registers: base (last written index) and ptr (working pointer), both IW bits.
- States: IDLE, IDX_HI (only if IDX_BYTES=2), IDX_LO, WDATA, RDATA.
- slv_start & !slv_rd, any state -> IDX_HI or IDX_LO; byte counter cleared.
- IDX_HI + slv_ws: base[15:8] <= wdat -> IDX_LO.
- IDX_LO + slv_ws: base[7:0] <= wdat; ptr <= new base -> WDATA.
- WDATA + slv_ws: if ptr<DEPTH and ptr<RO_BASE then mem[ptr] <= wdat, else discarded. Count++; ptr advances.
- slv_start & slv_rd, any state -> RDATA; ptr <= base (reads restart at last written index, not at the post-write pointer).
- RDATA + slv_rs: ptr advances.
- ptr advance:
  - WRAP=1: ptr==DEPTH-1 -> 0.
  - WRAP=0: increment to DEPTH, then hold. Writes there are discarded; reads return FILL.
- slv_rdat: registered; the cycle after any ptr/base/mem change it equals mem[ptr] (FILL if ptr>=DEPTH). The slave must leave >=2 clk between slv_rs and its next data load.
- slv_stop -> IDLE; base and ptr retained.
- wr_done: one cycle after the closing slv_stop/slv_start, when leaving WDATA with count>=1. wr_first/wr_count hold until the next wr_done.
- A STOP during IDX_HI/IDX_LO: partial index abandoned, base unchanged.
- Same-cycle slv_start and slv_stop: start wins.
- Host port: the write applies next edge if host_addr<DEPTH, ignoring RO_BASE. Same cycle, same index as an I2C write: I2C wins and host_coll pulses. Different indices: both write.
- Indices >= 2**IW are impossible by construction; DEPTH need not be a power of two.

Decomposition:
- Shared package/header (alongside the existing i2c defines):
  - state encodings (RF_IDLE, RF_IDXH, RF_IDXL, RF_WDAT, RF_RDAT)
  - clog2 helper function
- One sub-module: i2c_regfile_mem.
  - Synchronous 2-port byte RAM: port A I2C read/write, port B host read/write.
  - Port-A-wins collision flag; reset-to-zero clear.
- Controller FSM and pointer logic stay in the top level.

Test Plan:
- IDX_BYTES=1, DEPTH=16: start-W, idx 0x00, data 0x11..0x88, restart-R, 8 slv_rs -> slv_rdat 0x11,0x22..0x88; wr_done at restart with wr_first=0, wr_count=8.
- WRAP=1, DEPTH=16: idx 0x0E, write A0,A1,A2 -> mem[14]=A0, mem[15]=A1, mem[0]=A2. WRAP=0 same stimulus -> mem[0] unchanged; read from 0x0F returns A1 then FILL 0xFF.
- RO_BASE=8: host writes mem[9]=0x5A; I2C idx 9 write 0x00 -> mem[9] stays 0x5A, wr_count=1; I2C read of 9 returns 0x5A.
- IDX_BYTES=2, DEPTH=300: idx bytes 0x01,0x10, write 0xC3 -> host_rdat at addr 272 = 0xC3; STOP after only 0x01 leaves base unchanged.
- Same-cycle host_we and I2C slv_ws to index 3 (host 0x77, I2C 0x99) -> mem[3]=0x99, host_coll single pulse.
- aresetn low mid-WDATA after 2 of 4 bytes -> immediate IDLE, all outputs 0, mem cleared; subsequent full transaction behaves as the first scenario.

Source files
------------

// File: rtl/i2c_regfile_ctl_pkg.sv
// i2c_regfile_ctl_pkg: controller state encodings and sizing helper for the I2C register file
package i2c_regfile_ctl_pkg;

    typedef enum logic [2:0] {
        RF_IDLE,
        RF_IDXH,
        RF_IDXL,
        RF_WDAT,
        RF_RDAT
    } rf_state_t;

    // Bits needed to address v entries; at least 1 so a 1-deep array still has an index
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/i2c_regfile_mem.sv
// i2c_regfile_mem: 2-port byte register array, port A (I2C) wins same-index write collisions
module i2c_regfile_mem
    import i2c_regfile_ctl_pkg::*;
#(
    parameter int         DEPTH = 16,
    parameter int         AW    = 9,
    parameter logic [7:0] FILL  = 8'hFF
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic [AW-1:0] i_a_addr,
    input  logic          i_a_we,
    input  logic [7:0]    i_a_wdat,
    output logic [7:0]    o_a_rdat,
    input  logic [AW-1:0] i_b_addr,
    input  logic          i_b_we,
    input  logic [7:0]    i_b_wdat,
    output logic [7:0]    o_b_rdat,
    output logic          o_coll
);

    localparam int            MW  = clog2(DEPTH);
    localparam logic [AW-1:0] LIM = AW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic          w_a_in;
    logic          w_b_in;
    logic          w_a_we;
    logic          w_b_we;
    logic [MW-1:0] w_a_idx;
    logic [MW-1:0] w_b_idx;

    assign w_a_in  = i_a_addr < LIM;
    assign w_b_in  = i_b_addr < LIM;
    assign w_a_we  = i_a_we && w_a_in;
    assign w_b_we  = i_b_we && w_b_in;
    assign w_a_idx = i_a_addr[MW-1:0];
    assign w_b_idx = i_b_addr[MW-1:0];

    // Storage: port A is assigned last so it overrides port B on the same index
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_b_we) r_mem[w_b_idx] <= i_b_wdat;
            if (w_a_we) r_mem[w_a_idx] <= i_a_wdat;
        end
    end

    // Registered read ports (FILL outside the array) and one-cycle collision flag
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_a_rdat <= '0;
            o_b_rdat <= '0;
            o_coll   <= 1'b0;
        end else begin
            o_a_rdat <= w_a_in ? r_mem[w_a_idx] : FILL;
            o_b_rdat <= w_b_in ? r_mem[w_b_idx] : FILL;
            o_coll   <= w_a_we && w_b_we && (i_a_addr == i_b_addr);
        end
    end

endmodule

// File: rtl/i2c_regfile_ctl.sv
// i2c_regfile_ctl: register-file back end for an i2c_slave byte interface, with host port
module i2c_regfile_ctl
    import i2c_regfile_ctl_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         IDX_BYTES = 1,
    parameter int         WRAP      = 1,
    parameter int         RO_BASE   = DEPTH,
    parameter logic [7:0] FILL      = 8'hFF,
    localparam int        IW        = 8 * IDX_BYTES
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          slv_start,
    input  logic          slv_rd,
    input  logic          slv_stop,
    input  logic          slv_ws,
    input  logic [7:0]    slv_wdat,
    input  logic          slv_rs,
    output logic [7:0]    slv_rdat,
    input  logic [IW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdat,
    output logic [7:0]    host_rdat,
    output logic          host_coll,
    output logic          wr_done,
    output logic [IW-1:0] wr_first,
    output logic [IW:0]   wr_count
);

    // The pointer carries one extra bit so a saturated pointer can sit at DEPTH == 2**IW
    localparam logic [IW:0] DEP       = (IW + 1)'(DEPTH);
    localparam logic [IW:0] LAST      = DEP - 1'b1;
    localparam logic [IW:0] RO        = (IW + 1)'(RO_BASE);
    localparam rf_state_t   IDX_START = (IDX_BYTES == 2) ? RF_IDXH : RF_IDXL;

    rf_state_t     r_state;
    logic [IW-1:0] r_base;
    logic [IW:0]   r_ptr;
    logic [IW:0]   r_cnt;
    logic [7:0]    r_hi;
    logic [IW-1:0] w_new_base;
    logic [IW:0]   w_ptr_nxt;
    logic          w_close;
    logic          w_i2c_we;

    // The high index byte is staged in r_hi so an abandoned index never touches base
    assign w_new_base = IW'({r_hi, slv_wdat});
    assign w_ptr_nxt  = (WRAP != 0) ? ((r_ptr >= LAST) ? '0 : r_ptr + 1'b1)
                                    : ((r_ptr >= DEP) ? r_ptr : r_ptr + 1'b1);
    assign w_close    = (slv_start || slv_stop) && (r_state == RF_WDAT) && (r_cnt != '0);
    assign w_i2c_we   = (r_state == RF_WDAT) && slv_ws && !slv_start && !slv_stop
                        && (r_ptr < DEP) && (r_ptr < RO);

    // Controller: START beats STOP beats byte strobes; base/ptr survive STOP
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= RF_IDLE;
            r_base   <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            wr_done  <= 1'b0;
            wr_first <= '0;
            wr_count <= '0;
        end else begin
            wr_done <= w_close;
            if (w_close) begin
                wr_first <= r_base;
                wr_count <= r_cnt;
            end
            if (slv_start) begin
                r_cnt   <= '0;
                r_state <= slv_rd ? RF_RDAT : IDX_START;
                if (slv_rd) r_ptr <= {1'b0, r_base};
            end else if (slv_stop) begin
                r_state <= RF_IDLE;
            end else if (slv_ws && r_state == RF_IDXH) begin
                r_hi    <= slv_wdat;
                r_state <= RF_IDXL;
            end else if (slv_ws && r_state == RF_IDXL) begin
                r_base  <= w_new_base;
                r_ptr   <= {1'b0, w_new_base};
                r_state <= RF_WDAT;
            end else if (slv_ws && r_state == RF_WDAT) begin
                r_cnt <= r_cnt + 1'b1;
                r_ptr <= w_ptr_nxt;
            end else if (slv_rs && r_state == RF_RDAT) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    i2c_regfile_mem #(
        .DEPTH (DEPTH),
        .AW    (IW + 1),
        .FILL  (FILL)
    ) u_mem (
        .clk      (clk),
        .aresetn  (aresetn),
        .i_a_addr (r_ptr),
        .i_a_we   (w_i2c_we),
        .i_a_wdat (slv_wdat),
        .o_a_rdat (slv_rdat),
        .i_b_addr ({1'b0, host_addr}),
        .i_b_we   (host_we),
        .i_b_wdat (host_wdat),
        .o_b_rdat (host_rdat),
        .o_coll   (host_coll)
    );

endmodule

// File: tb/tb_i2c_regfile_ctl.sv
// tb_i2c_regfile_ctl: directed checks of four register-file configurations on one shared I2C bus
module tb_i2c_regfile_ctl;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        slv_start, slv_rd, slv_stop, slv_ws, slv_rs;
    logic [7:0]  slv_wdat;
    logic [7:0]  host_addr, host_wdat;
    logic        host_we;
    logic [15:0] h2_addr;
    logic [7:0]  h2_wdat;
    logic        h2_we;

    logic [7:0]  a_rdat, a_hrd, b_rdat, b_hrd, c_rdat, c_hrd, d_rdat, d_hrd;
    logic        a_coll, b_coll, c_coll, d_coll;
    logic        a_done, b_done, c_done, d_done;
    logic [7:0]  a_first, b_first, c_first;
    logic [8:0]  a_cnt, b_cnt, c_cnt;
    logic [15:0] d_first;
    logic [16:0] d_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // A: defaults (DEPTH 16, wrap); B: saturating; C: read-only from 8; D: 2-byte index, DEPTH 300
    i2c_regfile_ctl #(.DEPTH(16)) u_a (
        .clk(clk), .aresetn(aresetn), .slv_start(slv_start), .slv_rd(slv_rd), .slv_stop(slv_stop),
        .slv_ws(slv_ws), .slv_wdat(slv_wdat), .slv_rs(slv_rs), .slv_rdat(a_rdat),
        .host_addr(host_addr), .host_we(host_we), .host_wdat(host_wdat), .host_rdat(a_hrd),
        .host_coll(a_coll), .wr_done(a_done), .wr_first(a_first), .wr_count(a_cnt));

    i2c_regfile_ctl #(.DEPTH(16), .WRAP(0)) u_b (
        .clk(clk), .aresetn(aresetn), .slv_start(slv_start), .slv_rd(slv_rd), .slv_stop(slv_stop),
        .slv_ws(slv_ws), .slv_wdat(slv_wdat), .slv_rs(slv_rs), .slv_rdat(b_rdat),
        .host_addr(host_addr), .host_we(host_we), .host_wdat(host_wdat), .host_rdat(b_hrd),
        .host_coll(b_coll), .wr_done(b_done), .wr_first(b_first), .wr_count(b_cnt));

    i2c_regfile_ctl #(.DEPTH(16), .RO_BASE(8)) u_c (
        .clk(clk), .aresetn(aresetn), .slv_start(slv_start), .slv_rd(slv_rd), .slv_stop(slv_stop),
        .slv_ws(slv_ws), .slv_wdat(slv_wdat), .slv_rs(slv_rs), .slv_rdat(c_rdat),
        .host_addr(host_addr), .host_we(host_we), .host_wdat(host_wdat), .host_rdat(c_hrd),
        .host_coll(c_coll), .wr_done(c_done), .wr_first(c_first), .wr_count(c_cnt));

    i2c_regfile_ctl #(.DEPTH(300), .IDX_BYTES(2)) u_d (
        .clk(clk), .aresetn(aresetn), .slv_start(slv_start), .slv_rd(slv_rd), .slv_stop(slv_stop),
        .slv_ws(slv_ws), .slv_wdat(slv_wdat), .slv_rs(slv_rs), .slv_rdat(d_rdat),
        .host_addr(h2_addr), .host_we(h2_we), .host_wdat(h2_wdat), .host_rdat(d_hrd),
        .host_coll(d_coll), .wr_done(d_done), .wr_first(d_first), .wr_count(d_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ws(input logic [7:0] b);
        slv_wdat = b;
        slv_ws = 1'b1;
        tick();
        slv_ws = 1'b0;
    endtask

    task automatic st(input logic rd);
        slv_start = 1'b1;
        slv_rd = rd;
        tick();
        slv_start = 1'b0;
        slv_rd = 1'b0;
    endtask

    task automatic sp();
        slv_stop = 1'b1;
        tick();
        slv_stop = 1'b0;
    endtask

    task automatic rs();
        slv_rs = 1'b1;
        tick();
        slv_rs = 1'b0;
    endtask

    task automatic hrd(input logic [7:0] a);
        host_addr = a;
        tick();
    endtask

    // Write 0x11..0x88 from index 0, restart for read, read all eight back on instance A
    task automatic scen1();
        st(1'b0);
        ws(8'h00);
        for (int i = 0; i < 8; i++) ws(8'((i + 1) * 17));
        st(1'b1);
        chk("s1_done", 32'(a_done), 1);
        chk("s1_first", 32'(a_first), 0);
        chk("s1_count", 32'(a_cnt), 8);
        tick();
        chk("s1_done_pulse", 32'(a_done), 0);
        chk("s1_rd0", 32'(a_rdat), 'h11);
        for (int i = 1; i < 8; i++) begin
            rs();
            tick();
            chk("s1_rd", 32'(a_rdat), 32'((i + 1) * 17));
        end
        sp();
    endtask

    initial begin
        aresetn = 1'b0;
        {slv_start, slv_rd, slv_stop, slv_ws, slv_rs, host_we, h2_we} = '0;
        slv_wdat = '0; host_addr = '0; host_wdat = '0; h2_addr = '0; h2_wdat = '0;
        tick();
        tick();
        chk("rst_rdat", 32'(a_rdat), 0);
        chk("rst_hrdat", 32'(a_hrd), 0);
        chk("rst_coll", 32'(a_coll), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_first", 32'(a_first), 0);
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_d_rdat", 32'(d_rdat), 0);
        aresetn = 1'b1;
        tick();

        scen1();

        // Write A0..A2 from index 14: A wraps to 0, B saturates and drops A2
        st(1'b0);
        ws(8'h0E); ws(8'hA0); ws(8'hA1); ws(8'hA2);
        sp();
        chk("wrap_done", 32'(a_done), 1);
        chk("wrap_first", 32'(a_first), 14);
        chk("wrap_count", 32'(a_cnt), 3);
        chk("sat_count", 32'(b_cnt), 3);
        hrd(8'd14);
        chk("wrap_m14", 32'(a_hrd), 'hA0);
        hrd(8'd15);
        chk("wrap_m15", 32'(a_hrd), 'hA1);
        hrd(8'd0);
        chk("wrap_m0", 32'(a_hrd), 'hA2);
        chk("sat_m0", 32'(b_hrd), 'h11);
        st(1'b0);
        ws(8'h0F);
        st(1'b1);
        chk("restart_no_done", 32'(a_done), 0);
        tick();
        chk("wrap_rd15", 32'(a_rdat), 'hA1);
        chk("sat_rd15", 32'(b_rdat), 'hA1);
        rs();
        tick();
        chk("wrap_rd0", 32'(a_rdat), 'hA2);
        chk("sat_rd_fill", 32'(b_rdat), 'hFF);
        sp();

        // Host writes read-only index 9; I2C write there is counted but discarded on C
        host_addr = 8'd9; host_wdat = 8'h5A; host_we = 1'b1;
        tick();
        host_we = 1'b0;
        st(1'b0);
        ws(8'h09); ws(8'h00);
        sp();
        chk("ro_done", 32'(c_done), 1);
        chk("ro_first", 32'(c_first), 9);
        chk("ro_count", 32'(c_cnt), 1);
        hrd(8'd9);
        chk("ro_m9", 32'(c_hrd), 'h5A);
        chk("rw_m9", 32'(a_hrd), 'h00);
        st(1'b0);
        ws(8'h09);
        st(1'b1);
        tick();
        chk("ro_rd9", 32'(c_rdat), 'h5A);
        sp();

        // Two-byte index 0x0110 = 272 on D; then an abandoned index must leave base alone
        st(1'b0);
        ws(8'h01); ws(8'h10); ws(8'hC3);
        sp();
        chk("idx2_done", 32'(d_done), 1);
        chk("idx2_first", 32'(d_first), 272);
        chk("idx2_count", 32'(d_cnt), 1);
        h2_addr = 16'd272;
        tick();
        chk("idx2_m272", 32'(d_hrd), 'hC3);
        st(1'b0);
        ws(8'h00);
        sp();
        chk("idx2_partial_no_done", 32'(d_done), 0);
        st(1'b1);
        tick();
        chk("idx2_base_kept", 32'(d_rdat), 'hC3);
        sp();

        // Same-index host/I2C write at 3 (I2C wins, one-cycle flag), then different indices 4/5
        st(1'b0);
        ws(8'h03);
        host_addr = 8'd3; host_wdat = 8'h77; host_we = 1'b1;
        slv_wdat = 8'h99; slv_ws = 1'b1;
        tick();
        host_we = 1'b0; slv_ws = 1'b0;
        chk("coll_set", 32'(a_coll), 1);
        tick();
        chk("coll_pulse", 32'(a_coll), 0);
        host_addr = 8'd5; host_wdat = 8'h55; host_we = 1'b1;
        slv_wdat = 8'h44; slv_ws = 1'b1;
        tick();
        host_we = 1'b0; slv_ws = 1'b0;
        chk("coll_diff", 32'(a_coll), 0);
        sp();
        chk("coll_count", 32'(a_cnt), 2);
        hrd(8'd3);
        chk("coll_m3", 32'(a_hrd), 'h99);
        hrd(8'd4);
        chk("diff_m4", 32'(a_hrd), 'h44);
        hrd(8'd5);
        chk("diff_m5", 32'(a_hrd), 'h55);

        // Asynchronous reset in the middle of a write phase
        st(1'b0);
        ws(8'h00); ws(8'hDE); ws(8'hAD);
        aresetn = 1'b0;
        #1;
        chk("arst_rdat", 32'(a_rdat), 0);
        chk("arst_hrdat", 32'(a_hrd), 0);
        chk("arst_first", 32'(a_first), 0);
        chk("arst_count", 32'(a_cnt), 0);
        chk("arst_done", 32'(a_done), 0);
        chk("arst_d_hrdat", 32'(d_hrd), 0);
        tick();
        aresetn = 1'b1;
        hrd(8'd0);
        chk("arst_m0", 32'(a_hrd), 0);
        hrd(8'd1);
        chk("arst_m1", 32'(a_hrd), 0);
        chk("arst_no_done", 32'(a_done), 0);

        scen1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
